// File: rtl/flp_relu_seq_pkg.sv
// Shared constants for the ReLU sequencer: FSM encodings, FP32 format widths and the
// default leaky-slope exponent adjust.
package flp_relu_seq_pkg;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;

    localparam int unsigned FP32_EWIDTH = 8;
    localparam int unsigned FP32_SWIDTH = 23;

    // -4 in the EWIDTH-1 bit two's complement exponent-adjust field
    localparam logic [FP32_EWIDTH-2:0] LEAKY_E_DEFAULT = 7'h7C;

endpackage

// File: rtl/flp_relu.sv
// Combinational floating point ReLU: positives and NaNs pass, negatives go to +0 (plain)
// or have their exponent shifted by a signed adjust (leaky), saturating to -0 / -Inf.
module flp_relu #(
    parameter int unsigned EWIDTH = 8,
    parameter int unsigned SWIDTH = 23
) (
    input  logic                     i_l,
    input  logic [EWIDTH-2:0]        i_e,
    input  logic [EWIDTH+SWIDTH:0]   i_data,
    output logic [EWIDTH+SWIDTH:0]   o_data
);

    localparam int unsigned W = 1 + EWIDTH + SWIDTH;

    logic                     sgn;
    logic [EWIDTH-1:0]        exp_in;
    logic [SWIDTH-1:0]        man;
    logic                     exp_ones;
    logic                     is_nan;
    logic                     is_inf;
    logic signed [EWIDTH+1:0] exp_adj;
    logic                     adj_underflow;
    logic                     adj_overflow;

    assign sgn      = i_data[W-1];
    assign exp_in   = i_data[W-2:SWIDTH];
    assign man      = i_data[SWIDTH-1:0];
    assign exp_ones = &exp_in;
    assign is_nan   = exp_ones && (man != '0);
    assign is_inf   = exp_ones && (man == '0);

    assign exp_adj = $signed({2'b00, exp_in}) + $signed({{3{i_e[EWIDTH-2]}}, i_e});

    // Denormal inputs and adjusted exponents <= 0 flush to signed zero
    assign adj_underflow = exp_adj[EWIDTH+1] || (exp_adj == '0) || (exp_in == '0);
    assign adj_overflow  = !exp_adj[EWIDTH+1] && (exp_adj[EWIDTH:0] >= {1'b0, {EWIDTH{1'b1}}});

    always_comb begin
        o_data = i_data;
        if (sgn && !is_nan) begin
            if (!i_l) begin
                o_data = '0;
            end else if (is_inf) begin
                o_data = i_data;
            end else if (adj_underflow) begin
                o_data = {1'b1, {(W-1){1'b0}}};
            end else if (adj_overflow) begin
                o_data = {1'b1, {EWIDTH{1'b1}}, {SWIDTH{1'b0}}};
            end else begin
                o_data = {1'b1, exp_adj[EWIDTH-1:0], man};
            end
        end
    end

endmodule

// File: rtl/flp_relu_seq.sv
// Command-driven sequencer streaming a counted block of operands through flp_relu into a
// registered valid/ready output, with a one-cycle done pulse after the last result leaves.
module flp_relu_seq
    import flp_relu_seq_pkg::*;
#(
    parameter int unsigned EWIDTH = FP32_EWIDTH,
    parameter int unsigned SWIDTH = FP32_SWIDTH,
    parameter int unsigned CWIDTH = 16
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   i_cmd_vld,
    output logic                   o_cmd_rdy,
    input  logic [CWIDTH-1:0]      i_cmd_cnt,
    input  logic                   i_cmd_l,
    input  logic [EWIDTH-2:0]      i_cmd_e,
    input  logic                   i_in_vld,
    output logic                   o_in_rdy,
    input  logic [EWIDTH+SWIDTH:0] i_in_data,
    output logic                   o_out_vld,
    input  logic                   i_out_rdy,
    output logic [EWIDTH+SWIDTH:0] o_out_data,
    output logic                   o_busy,
    output logic                   o_done
);

    localparam int unsigned W = 1 + EWIDTH + SWIDTH;

    logic [1:0]        state_q, state_d;
    logic [CWIDTH-1:0] rem_q, rem_d;
    logic              l_q, l_d;
    logic [EWIDTH-2:0] e_q, e_d;
    logic              out_vld_q, out_vld_d;
    logic [W-1:0]      out_data_q, out_data_d;
    logic              done_q, done_d;
    logic [W-1:0]      relu_data;
    logic              cmd_xfer, in_xfer, out_xfer;

    flp_relu #(
        .EWIDTH (EWIDTH),
        .SWIDTH (SWIDTH)
    ) u_relu (
        .i_l    (l_q),
        .i_e    (e_q),
        .i_data (i_in_data),
        .o_data (relu_data)
    );

    assign o_cmd_rdy  = (state_q == StIdle);
    // Input may advance only when the output slot is free or draining this cycle
    assign o_in_rdy   = (state_q == StRun) && (rem_q != '0) && (!out_vld_q || i_out_rdy);
    assign o_out_vld  = out_vld_q;
    assign o_out_data = out_data_q;
    assign o_busy     = (state_q != StIdle);
    assign o_done     = done_q;

    assign cmd_xfer = i_cmd_vld && o_cmd_rdy;
    assign in_xfer  = i_in_vld && o_in_rdy;
    assign out_xfer = out_vld_q && i_out_rdy;

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        l_d        = l_q;
        e_d        = e_q;
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        done_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cmd_xfer) begin
                    l_d   = i_cmd_l;
                    e_d   = i_cmd_e;
                    rem_d = i_cmd_cnt;
                    if (i_cmd_cnt == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (in_xfer) begin
                    rem_d = rem_q - {{(CWIDTH-1){1'b0}}, 1'b1};
                    if (rem_q == {{(CWIDTH-1){1'b0}}, 1'b1}) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (out_xfer) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (in_xfer) begin
            out_vld_d  = 1'b1;
            out_data_d = relu_data;
        end else if (out_xfer) begin
            out_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= StIdle;
            rem_q      <= '0;
            l_q        <= 1'b0;
            e_q        <= '0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            l_q        <= l_d;
            e_q        <= e_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: doc/flp_relu_seq.md
Name: flp_relu_seq

Overview:
- Command-driven sequencer for the floating point ReLU datapath (flp_relu).
- Accepts one command: element count, plain/leaky mode and leaky exponent adjust. It then streams that many operands from an input valid/ready channel through one flp_relu instance, registers each result and drives it onto an output valid/ready channel.
- Sits between the vector engine's operand fetch and writeback paths.
- Pulses done when the last result has been taken.

Parameters:
- EWIDTH, 8, exponent width of the FP format.
- SWIDTH, 23, significand width (without hidden bit); data width W = 1+EWIDTH+SWIDTH.
- CWIDTH, 16, element count width.

Ports:
- clk  in  1  clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- i_cmd_vld  in  1  command valid.
- o_cmd_rdy  out  1  command ready; high only in IDLE.
- i_cmd_cnt  in  CWIDTH  number of elements.
- i_cmd_l  in  1  0 = plain ReLU, 1 = leaky ReLU.
- i_cmd_e  in  EWIDTH-1  signed exponent adjust for leaky slope (two's complement, e.g. -4 = 7'b1111100).
- i_in_vld  in  1  operand valid.
- o_in_rdy  out  1  operand ready.
- i_in_data  in  W  operand.
- o_out_vld  out  1  result valid.
- i_out_rdy  in  1  result ready.
- o_out_data  out  W  result.
- o_busy  out  1  high while state != IDLE.
- o_done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (nrst low, asynchronous):
  - State goes to IDLE; all counters and mode registers clear.
  - o_out_vld, o_done and o_busy go to 0, o_out_data to 0, o_cmd_rdy to 1 after reset.
  - Reset mid-operation drops any in-flight result and the remaining count. No done pulse is issued.
- Handshakes: a transfer occurs on a channel when vld && rdy at a rising clk edge. The input side must not depend combinationally on i_in_vld; only o_in_rdy may depend on i_out_rdy.
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - o_cmd_rdy = 1.
  - On command transfer, latch i_cmd_l, i_cmd_e and i_cmd_cnt into the remaining-input counter rem.
  - If i_cmd_cnt == 0: stay in IDLE and pulse o_done in the next cycle.
  - Otherwise go to RUN.
- RUN:
  - o_in_rdy = (rem != 0) && (!o_out_vld || i_out_rdy).
  - On input transfer, the output register loads the flp_relu result of i_in_data under the latched l/e, o_out_vld is set, and rem decrements.
  - When the transfer consumes the last element (rem == 1), go to DRAIN.
- DRAIN:
  - o_in_rdy = 0.
  - On output transfer, clear o_out_vld, pulse o_done in the same edge's next cycle, and go to IDLE.
- Output register: on output transfer without a simultaneous input transfer, o_out_vld clears. On simultaneous input and output transfers, the new result replaces the old one and o_out_vld stays 1.
- Timing: latency is 1 cycle from input transfer to o_out_vld. Throughput is 1 element/cycle with i_out_rdy held high.
- Stability: o_out_data and o_out_vld stay stable while o_out_vld && !i_out_rdy.
- o_done: timing is fixed per the IDLE and DRAIN rules above. A new command may be accepted in the cycle o_done is high, because the state is already IDLE.
- Command sampling: i_cmd_l and i_cmd_e are sampled only at command accept; changes during RUN/DRAIN have no effect.
- The counter never underflows; rem == 0 blocks further operand requests.
- FP semantics (NaN/Inf/zero/leaky scaling) are entirely those of flp_relu; this block adds no arithmetic.

Decomposition:
- Shared header/package holds:
  - FSM state encodings (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2).
  - FP32 constants EWIDTH=8 and SWIDTH=23.
  - The leaky default exponent constant -4.
- One sub-module: flp_relu (existing), instantiated once with EWIDTH/SWIDTH passed through; i_l and i_e come from the latched command registers.

Test Plan:
- Plain, cnt=4, inputs 41800000, c1800000, 80000000, 7f800000, i_out_rdy=1:
  - Outputs are 41800000, 00000000, 00000000, 7f800000 on consecutive cycles.
  - o_done pulses once after the 4th output.
- Leaky, e=-4, cnt=3, inputs c1800000, ff800000, ffffffff -> outputs bf800000, ff800000, ffffffff.
- Backpressure: cnt=2, i_out_rdy low for 3 cycles after the first result:
  - o_out_data stays 41800000.
  - o_in_rdy stays 0 during the stall.
  - The second operand is accepted in the cycle i_out_rdy rises.
- cnt=0 command:
  - o_in_rdy never asserts.
  - o_done pulses in the cycle after accept.
  - o_cmd_rdy stays 1.
- Mode isolation: toggle i_cmd_l to 0 during a leaky run of c1800000 -> the result is still bf800000.
- Reset mid-run: assert nrst with cnt=5 after 2 elements.
  - o_out_vld and o_busy drop immediately; no o_done.
  - A subsequent cnt=1 command of 41800000 completes normally.
